// File: rtl/mult16_seq_ctrl_pkg.sv
// mult16_seq_ctrl_pkg: shared state type, default sizes and step-count helper for the sequential multiplier
package mult16_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;
  function automatic int nstep(input int width, input int digit);
    return (width / digit) * (width / digit);
  endfunction
endpackage

// File: rtl/mult16_seq_ctrl_if.sv
// mult16_seq_ctrl_if: operand/product valid-ready bus of the sequential multiplier
interface mult16_seq_ctrl_if #(parameter int WIDTH = 16);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/mult16_seq_ctrl_digit.sv
// mult16_seq_ctrl_digit: combinational DIGIT x DIGIT unsigned digit multiplier
module mult16_seq_ctrl_digit #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0]   i_a,
  input  logic [DIGIT-1:0]   i_b,
  output logic [2*DIGIT-1:0] o_p
);
  assign o_p = (2*DIGIT)'(i_a) * (2*DIGIT)'(i_b);
endmodule

// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl: sequential unsigned multiplier walking all digit partial products through one shared digit multiplier
module mult16_seq_ctrl
  import mult16_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input logic             clk,
  input logic             rst,
  mult16_seq_ctrl_if.slave bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = $clog2(ND);
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW);
  mult_state_t        r_state, w_next;
  logic [CW-1:0]      r_i, r_j;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [PW-1:0]      r_acc;
  logic [2*DIGIT-1:0] w_pp;
  logic [SW-1:0]      w_sh;
  logic               w_jwrap, w_last, w_accept;
  assign w_jwrap  = r_j == CW'(ND - 1);
  assign w_last   = w_jwrap && (r_i == CW'(ND - 1));
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_sh     = SW'(DIGIT * (int'(r_i) + int'(r_j)));
  mult16_seq_ctrl_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a(r_a[r_i*DIGIT +: DIGIT]),
    .i_b(r_b[r_j*DIGIT +: DIGIT]),
    .o_p(w_pp)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (bus.in_valid ? CALC : IDLE) :
             r_state == CALC ? (w_last ? DONE : CALC) :
                               (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.busy      = r_state != IDLE;
    bus.product   = r_state == DONE ? r_acc : '0;
  end
  // j is the fast digit index; i advances each time j wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (r_state == CALC) begin
      r_acc <= r_acc + (PW'(w_pp) << w_sh);
      r_j   <= w_jwrap ? '0 : r_j + 1'b1;
      if (w_jwrap) r_i <= w_last ? '0 : r_i + 1'b1;
    end
  end
endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb_mult16_seq_ctrl: self-checking bench for the sequential multiplier against a product/latency reference model
module tb_mult16_seq_ctrl;
  localparam int LAT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors  = 0;
  mult16_seq_ctrl_if #(.WIDTH(16)) bus ();
  mult16_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat, output logic [31:0] p);
    int n = 0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    step();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    p = bus.product;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.product !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy/val/busy=%b product=%h expected 100/00000000", {bus.in_ready, bus.out_valid, bus.busy}, bus.product);
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] p;
    bus.out_ready = 1'b1;
    issue(16'd3, 16'd5, lat, p);
    vectors++;
    if (lat !== LAT || p !== 32'h0000000F) begin
      errors++;
      $display("FAIL basic: lat=%0d product=%h expected %0d/0000000f", lat, p, LAT);
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags: busy=%b in_ready=%b expected 1/0", bus.busy, bus.in_ready);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_max();
    int lat; logic [31:0] p;
    bus.out_ready = 1'b1;
    issue(16'hFFFF, 16'hFFFF, lat, p);
    vectors++;
    if (lat !== LAT || p !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL max: lat=%0d product=%h expected %0d/fffe0001", lat, p, LAT);
    end
    step();
  endtask

  task automatic test_zero();
    int lat; logic [31:0] p;
    bus.out_ready = 1'b1;
    issue(16'h0000, 16'h1234, lat, p);
    vectors++;
    if (lat !== LAT || p !== 32'h0) begin
      errors++;
      $display("FAIL zero: lat=%0d product=%h expected %0d/00000000", lat, p, LAT);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] p;
    bus.out_ready = 1'b0;
    issue(16'h1234, 16'h5678, lat, p);
    vectors++;
    if (lat !== LAT || p !== 32'h06260060) begin
      errors++;
      $display("FAIL bp_product: lat=%0d product=%h expected %0d/06260060", lat, p, LAT);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== 32'h06260060) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b product=%h expected 1/0/06260060", k, bus.out_valid, bus.in_ready, bus.product);
      end
    end
    bus.out_ready = 1'b1;
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h00FF; bus.b = 16'h0101;
    step();
    bus.a = 16'h8000; bus.b = 16'h0002;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin step(); lat++; end
    vectors++;
    if (lat !== LAT || bus.product !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d product=%h expected %0d/0000ffff", lat, bus.product, LAT);
    end
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy);
    end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin step(); lat++; end
    vectors++;
    if (lat !== LAT || bus.product !== 32'h00010000) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d product=%h expected %0d/00010000", lat, bus.product, LAT);
    end
    step();
  endtask

  task automatic test_abort();
    int lat; logic [31:0] p; logic seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'hABCD; bus.b = 16'h1111;
    step();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      seen |= bus.out_valid;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (seen !== 1'b0 || {bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || bus.product !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: seen=%b rdy/val/busy=%b product=%h expected 0/100/00000000", seen, {bus.in_ready, bus.out_valid, bus.busy}, bus.product);
    end
    issue(16'd2, 16'd7, lat, p);
    vectors++;
    if (lat !== LAT || p !== 32'h0000000E) begin
      errors++;
      $display("FAIL abort_next: lat=%0d product=%h expected %0d/0000000e", lat, p, LAT);
    end
    step();
  endtask

  task automatic test_random();
    int lat, hold; logic [15:0] a, b; logic [31:0] p, exp;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 50 == 0) a = '0;
      if (n % 50 == 1) b = 16'hFFFF;
      exp = model(a, b);
      bus.out_ready = 1'($urandom);
      issue(a, b, lat, p);
      vectors++;
      if (lat !== LAT || p !== exp) begin
        errors++;
        $display("FAIL random[%0d] %h*%h: lat=%0d product=%h expected %0d/%h", n, a, b, lat, p, LAT, exp);
      end
      if (!bus.out_ready) begin
        hold = $urandom_range(1, 3);
        for (int k = 0; k < hold; k++) begin
          step();
          vectors++;
          if (bus.out_valid !== 1'b1 || bus.product !== exp) begin
            errors++;
            $display("FAIL random_hold[%0d]: out_valid=%b product=%h expected 1/%h", n, bus.out_valid, bus.product, exp);
          end
        end
        bus.out_ready = 1'b1;
      end
      step();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_handshake[%0d]: out_valid=%b in_ready=%b expected 0/1", n, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
